// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SEC_WRAP_DEF = 59;
  localparam int unsigned MIN_WRAP_DEF = 59;

  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Decimal digit split of a wrap constant, so comparisons stay in BCD.
  function automatic logic [DIGIT_W-1:0] ones_of(input int unsigned v);
    return DIGIT_W'(v % 10);
  endfunction

  function automatic logic [DIGIT_W-1:0] tens_of(input int unsigned v);
    return DIGIT_W'((v / 10) % 10);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse per rising edge of d.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic s1_q, s2_q, dly_q;
  logic s1_d, s2_d, dly_d;

  always_comb begin
    s1_d  = d;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  assign pulse = s2_q & ~dly_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch: synchronized tick/button edges drive an IDLE/RUN/PAUSE FSM and a BCD cascade.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_WRAP = SEC_WRAP_DEF,
  parameter int unsigned MIN_WRAP = MIN_WRAP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slow_clk,
  input  logic               btn_ss,
  input  logic               btn_clr,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               running,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] SO_MAX = ones_of(SEC_WRAP);
  localparam logic [DIGIT_W-1:0] ST_MAX = tens_of(SEC_WRAP);
  localparam logic [DIGIT_W-1:0] MO_MAX = ones_of(MIN_WRAP);
  localparam logic [DIGIT_W-1:0] MT_MAX = tens_of(MIN_WRAP);

  logic tick, ss_p, clr_p;

  sync_edge u_sync_tick (.clk(clk), .reset(reset), .d(slow_clk), .pulse(tick));
  sync_edge u_sync_ss   (.clk(clk), .reset(reset), .d(btn_ss),   .pulse(ss_p));
  sync_edge u_sync_clr  (.clk(clk), .reset(reset), .d(btn_clr),  .pulse(clr_p));

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic               running_q, running_d;
  logic               wrap_q, wrap_d;
  logic               count_en;

  always_comb begin
    state_d  = state_q;
    so_d     = so_q;
    st_d     = st_q;
    mo_d     = mo_q;
    mt_d     = mt_q;
    wrap_d   = 1'b0;
    count_en = 1'b0;

    if (clr_p) begin
      state_d = IDLE;
      so_d    = '0;
      st_d    = '0;
      mo_d    = '0;
      mt_d    = '0;
    end else begin
      // A tick coinciding with start/stop counts only if we were already running.
      case (state_q)
        IDLE:    if (ss_p) state_d = RUN;
        RUN: begin
          count_en = tick;
          if (ss_p) state_d = PAUSE;
        end
        PAUSE:   if (ss_p) state_d = RUN;
        default: state_d = IDLE;
      endcase

      if (count_en) begin
        if (so_q == SO_MAX && st_q == ST_MAX) begin
          so_d = '0;
          st_d = '0;
          if (mo_q == MO_MAX && mt_q == MT_MAX) begin
            mo_d   = '0;
            mt_d   = '0;
            wrap_d = 1'b1;
          end else if (mo_q == ONES_MAX) begin
            mo_d = '0;
            mt_d = mt_q + 4'd1;
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else if (so_q == ONES_MAX) begin
          so_d = '0;
          st_d = st_q + 4'd1;
        end else begin
          so_d = so_q + 4'd1;
        end
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      so_q      <= '0;
      st_q      <= '0;
      mo_q      <= '0;
      mt_q      <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      so_q      <= so_d;
      st_q      <= st_d;
      mo_q      <= mo_d;
      mt_q      <= mt_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign running  = running_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: start, pause, carry, wrap, simultaneous events, async reset.
module tb_stopwatch_bcd;

  logic       clk;
  logic       reset;
  logic       slow_clk;
  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd dut (
    .clk      (clk),
    .reset    (reset),
    .slow_clk (slow_clk),
    .btn_ss   (btn_ss),
    .btn_clr  (btn_clr),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive the selected inputs high for 2 cycles, then low for 2 (minimum legal pulse).
  task automatic pulse_in(input logic s, input logic ss, input logic clr);
    @(negedge clk);
    slow_clk = s;
    btn_ss   = ss;
    btn_clr  = clr;
    cycles(2);
    slow_clk = 1'b0;
    btn_ss   = 1'b0;
    btn_clr  = 1'b0;
    cycles(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_in(1'b1, 1'b0, 1'b0);
  endtask

  int wrap_cnt;
  int run_low;

  initial begin
    reset    = 1'b0;
    slow_clk = 1'b0;
    btn_ss   = 1'b0;
    btn_clr  = 1'b0;

    // Reset and start
    cycles(5);
    chk("rst_digits", 32'(digits()), 32'h0000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    reset = 1'b1;
    cycles(2);
    btn_ss = 1'b1;
    @(negedge clk);
    chk("start_run_n0", 32'(running), 32'd0);
    @(negedge clk);
    chk("start_run_n1", 32'(running), 32'd0);
    @(negedge clk);
    chk("start_run_n2", 32'(running), 32'd1);
    btn_ss = 1'b0;
    cycles(2);
    ticks(3);
    chk("start_0003", 32'(digits()), 32'h0003);

    // Pause / resume
    ticks(4);
    chk("pre_pause_0007", 32'(digits()), 32'h0007);
    pulse_in(1'b0, 1'b1, 1'b0);
    chk("pause_running", 32'(running), 32'd0);
    ticks(4);
    chk("pause_hold_0007", 32'(digits()), 32'h0007);
    pulse_in(1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("resume_0009", 32'(digits()), 32'h0009);
    chk("resume_running", 32'(running), 32'd1);

    // Carry chain
    pulse_in(1'b0, 1'b0, 1'b1);
    chk("clr_digits", 32'(digits()), 32'h0000);
    chk("clr_running", 32'(running), 32'd0);
    pulse_in(1'b0, 1'b1, 1'b0);
    ticks(59);
    chk("carry_0059", 32'(digits()), 32'h0059);
    ticks(1);
    chk("carry_0100", 32'(digits()), 32'h0100);
    ticks(9);
    chk("carry_0109", 32'(digits()), 32'h0109);

    // Simultaneous events
    pulse_in(1'b0, 1'b0, 1'b1);
    pulse_in(1'b0, 1'b1, 1'b0);
    ticks(4);
    chk("sim_pre_0004", 32'(digits()), 32'h0004);
    pulse_in(1'b1, 1'b1, 1'b0);
    chk("sim_run_0005", 32'(digits()), 32'h0005);
    chk("sim_run_paused", 32'(running), 32'd0);
    ticks(1);
    chk("sim_paused_hold", 32'(digits()), 32'h0005);
    pulse_in(1'b1, 1'b1, 1'b0);
    chk("sim_pause_running", 32'(running), 32'd1);
    chk("sim_pause_0005", 32'(digits()), 32'h0005);
    pulse_in(1'b1, 1'b1, 1'b1);
    chk("sim_clr_running", 32'(running), 32'd0);
    chk("sim_clr_digits", 32'(digits()), 32'h0000);
    ticks(1);
    chk("sim_idle_hold", 32'(digits()), 32'h0000);

    // Wrap
    pulse_in(1'b0, 1'b1, 1'b0);
    ticks(3599);
    chk("wrap_5959", 32'(digits()), 32'h5959);
    chk("wrap_pre_flag", 32'(wrap), 32'd0);
    wrap_cnt = 0;
    run_low  = 0;
    @(negedge clk);
    slow_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) slow_clk = 1'b0;
      if (wrap === 1'b1) wrap_cnt++;
      if (running !== 1'b1) run_low++;
    end
    chk("wrap_0000", 32'(digits()), 32'h0000);
    chk("wrap_pulse_cnt", 32'(wrap_cnt), 32'd1);
    chk("wrap_running", 32'(run_low), 32'd0);

    // Reset mid-run
    ticks(754);
    chk("mid_1234", 32'(digits()), 32'h1234);
    @(posedge clk);
    #20 reset = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(digits()), 32'h0000);
    chk("mid_rst_running", 32'(running), 32'd0);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    cycles(3);
    reset = 1'b1;
    cycles(2);
    ticks(3);
    chk("post_rst_idle", 32'(digits()), 32'h0000);
    chk("post_rst_running", 32'(running), 32'd0);
    pulse_in(1'b0, 1'b1, 1'b0);
    ticks(1);
    chk("post_rst_0001", 32'(digits()), 32'h0001);
    chk("post_rst_run", 32'(running), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
